// File: rtl/vproc_instr_commit_queue.sv
// In-order instruction queue: entries wait speculative until resolved by ID, then drain from the head.
// Optional VPROC_IQ_KILL_DROP_EN: killed heads are dropped internally instead of being presented.
module vproc_instr_commit_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     async_rst_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [ID_W-1:0]          enq_id_i,
  input  logic [2:0]               enq_unit_i,
  input  logic [DATA_W-1:0]        enq_data_i,
  input  logic                     commit_valid_i,
  input  logic [ID_W-1:0]          commit_id_i,
  input  logic                     commit_kill_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [ID_W-1:0]          deq_id_o,
  output logic [2:0]               deq_unit_o,
  output logic [DATA_W-1:0]        deq_data_o,
`ifndef VPROC_IQ_KILL_DROP_EN
  output logic                     deq_killed_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {INVALID, SPECULATIVE, COMMITTED, KILLED} instr_state_e;

  instr_state_e      state_q [DEPTH];
  instr_state_e      state_d [DEPTH];
  logic [ID_W-1:0]   id_q    [DEPTH];
  logic [2:0]        unit_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [PTR_W:0]    count_q;
  instr_state_e      head_state, resolved_state;
  logic              enq_fire, pop;

  assign head_state     = state_q[head_q];
  assign resolved_state = commit_kill_i ? KILLED : COMMITTED;
  assign enq_ready_o    = (count_q < FULL_CNT);
  assign enq_fire       = enq_valid_i & enq_ready_o;

`ifdef VPROC_IQ_KILL_DROP_EN
  // A killed head never reaches the consumer; it is retired on its own, one per cycle.
  assign deq_valid_o = (head_state == COMMITTED);
  assign pop         = (deq_valid_o & deq_ready_i) | (head_state == KILLED);
`else
  assign deq_valid_o  = (head_state == COMMITTED) || (head_state == KILLED);
  assign deq_killed_o = (head_state == KILLED);
  assign pop          = deq_valid_o & deq_ready_i;
`endif

  assign deq_id_o   = id_q[head_q];
  assign deq_unit_o = unit_q[head_q];
  assign deq_data_o = data_q[head_q];
  assign count_o    = count_q;

  // Resolve first, then retire the head, then write the tail; the tail slot is
  // always INVALID when written, so a same-cycle commit must be folded in here.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      if (commit_valid_i && (state_q[i] == SPECULATIVE) && (id_q[i] == commit_id_i))
        state_d[i] = resolved_state;
    end
    if (pop)
      state_d[head_q] = INVALID;
    if (enq_fire)
      state_d[tail_q] = (commit_valid_i && (commit_id_i == enq_id_i)) ? resolved_state : SPECULATIVE;
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        state_q[i] <= INVALID;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop)
        head_q <= head_q + 1'b1;
      if (enq_fire)
        tail_q <= tail_q + 1'b1;
      if (enq_fire && !pop)
        count_q <= count_q + 1'b1;
      else if (!enq_fire && pop)
        count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      id_q[tail_q]   <= enq_id_i;
      unit_q[tail_q] <= enq_unit_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

endmodule

// File: tb/tb_vproc_instr_commit_queue.sv
// Randomized scoreboard bench for vproc_instr_commit_queue (default build, killed heads presented).
module tb_vproc_instr_commit_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        async_rst_i = 1'b1;
  logic        enq_valid_i = 1'b0;
  logic        enq_ready_o;
  logic [2:0]  enq_id_i = '0;
  logic [2:0]  enq_unit_i = '0;
  logic [31:0] enq_data_i = '0;
  logic        commit_valid_i = 1'b0;
  logic [2:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        deq_valid_o;
  logic        deq_ready_i = 1'b0;
  logic [2:0]  deq_id_o;
  logic [2:0]  deq_unit_o;
  logic [31:0] deq_data_o;
  logic        deq_killed_o;
  logic [2:0]  count_o;

  vproc_instr_commit_queue #(.DEPTH(DEPTH), .ID_W(3), .DATA_W(32)) dut (
    .clk_i(clk), .async_rst_i(async_rst_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_id_i(enq_id_i), .enq_unit_i(enq_unit_i), .enq_data_i(enq_data_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_id_o(deq_id_o), .deq_unit_o(deq_unit_o), .deq_data_o(deq_data_o),
    .deq_killed_o(deq_killed_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Reference: ordered list of outstanding instructions with their resolution.
  typedef enum int {SPEC, DONE, DEAD} res_e;
  typedef struct {
    logic [2:0]  id;
    logic [2:0]  unit;
    logic [31:0] data;
    res_e        res;
  } ent_t;

  ent_t exp_q[$];
  bit   pop_pend = 0;
  int   checks = 0;
  int   failures = 0;
  int   max_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model advances on the same edge as the DUT, using only bench inputs and its own list.
  always @(posedge clk) begin
    if (async_rst_i) begin
      exp_q.delete();
    end else begin
      int  sz;
      bit  enq_ok;
      sz = exp_q.size();
      enq_ok = (sz < DEPTH);
      if (commit_valid_i)
        foreach (exp_q[k])
          if (exp_q[k].res == SPEC && exp_q[k].id == commit_id_i)
            exp_q[k].res = commit_kill_i ? DEAD : DONE;
      if (pop_pend)
        void'(exp_q.pop_front());
      if (enq_valid_i && enq_ok) begin
        ent_t e;
        e.id = enq_id_i; e.unit = enq_unit_i; e.data = enq_data_i;
        e.res = (commit_valid_i && commit_id_i == enq_id_i) ? (commit_kill_i ? DEAD : DONE) : SPEC;
        exp_q.push_back(e);
      end
      if (exp_q.size() > max_cnt) max_cnt = exp_q.size();
    end
    pop_pend = 0;
  end

  // Monitor: mid-cycle, compare DUT outputs with the model head and schedule the pop.
  always @(negedge clk) begin
    if (!async_rst_i) begin
      bit exp_v;
      exp_v = (exp_q.size() > 0) && (exp_q[0].res != SPEC);
      check("count", 32'(count_o), 32'(exp_q.size()));
      check("enq_ready", 32'(enq_ready_o), 32'(exp_q.size() < DEPTH));
      check("deq_valid", 32'(deq_valid_o), 32'(exp_v));
      if (exp_v && deq_valid_o) begin
        check("deq_id", 32'(deq_id_o), 32'(exp_q[0].id));
        check("deq_unit", 32'(deq_unit_o), 32'(exp_q[0].unit));
        check("deq_data", deq_data_o, exp_q[0].data);
        check("deq_killed", 32'(deq_killed_o), 32'(exp_q[0].res == DEAD));
        if (deq_ready_i) pop_pend = 1;
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+2), then advance to the next posedge+2.
  task automatic step(input bit ev, input logic [2:0] id, input logic [2:0] unit, input logic [31:0] d,
                      input bit cv, input logic [2:0] cid, input bit ck, input bit rdy);
    enq_valid_i = ev; enq_id_i = id; enq_unit_i = unit; enq_data_i = d;
    commit_valid_i = cv; commit_id_i = cid; commit_kill_i = ck; deq_ready_i = rdy;
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic drain();
    for (int c = 0; c < 8; c++) step(0, 0, 0, 0, 1, 3'(c), 1'(c % 2), 1);
    idle(DEPTH + 2, 1);
  endtask

  initial begin
    #1;
    check("rst_count", 32'(count_o), 0);
    check("rst_deq_valid", 32'(deq_valid_o), 0);
    check("rst_enq_ready", 32'(enq_ready_o), 1);
    check("rst_killed", 32'(deq_killed_o), 0);
    #11 async_rst_i = 1'b0;
    @(posedge clk); #2;

    // Out-of-order resolution, in-order drain
    step(1, 1, 1, 32'hA001, 0, 0, 0, 1);
    step(1, 2, 2, 32'hA002, 0, 0, 0, 1);
    step(1, 3, 3, 32'hA003, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 2, 0, 1);
    idle(2, 1);
    step(0, 0, 0, 0, 1, 1, 0, 1);
    idle(3, 1);
    drain();

    // Kill then commit
    step(1, 5, 4, 32'hB005, 0, 0, 0, 0);
    step(1, 6, 5, 32'hB006, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 1, 0);
    step(0, 0, 0, 0, 1, 6, 0, 0);
    idle(2, 0);
    idle(3, 1);

    // Enqueue resolved in the same cycle
    step(1, 7, 6, 32'hC007, 1, 7, 0, 1);
    idle(2, 1);

    // Full queue, then pop with enqueue held
    for (int i = 0; i < DEPTH; i++) step(1, 3'(i), 3'(i), 32'hD000 + 32'(i), 1, 3'(i), 0, 0);
    step(1, 4, 7, 32'hD004, 0, 0, 0, 0);
    step(1, 4, 7, 32'hD004, 0, 0, 0, 1);
    step(1, 5, 7, 32'hD005, 0, 0, 0, 0);
    idle(2, 0);
    drain();

    // Asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) step(1, 3'(i), 0, 32'hE000 + 32'(i), 0, 0, 0, 0);
    enq_valid_i = 0;
    #1 async_rst_i = 1'b1;
    exp_q.delete();
    pop_pend = 0;
    #1;
    check("async_count", 32'(count_o), 0);
    check("async_deq_valid", 32'(deq_valid_o), 0);
    check("async_enq_ready", 32'(enq_ready_o), 1);
    #3 async_rst_i = 1'b0;
    @(posedge clk); #2;

    // Wrap rounds with toggling ready
    for (int r = 0; r < 10; r++) begin
      step(1, 3'(r), 3'(r), 32'hF000 + 32'(r), 1, 3'(r), 0, 1'(r % 2));
      step(0, 0, 0, 0, 0, 0, 0, 1'((r + 1) % 2));
    end
    idle(4, 1);

    // Randomized traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 99) < 60, 3'($urandom), 3'($urandom), $urandom,
           $urandom_range(0, 99) < 55, 3'($urandom), $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 65);
    drain();
    drain();
    check("max_count", 32'(max_cnt <= DEPTH), 1);
    check("final_count", 32'(count_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
